shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Multi-cycle shift sequencer for the RV32 execute path. It accepts one SLL/SRL/SRA request through a valid/ready handshake and drives a single shared barrel-shifter stage. Each cycle it applies one power-of-two layer of the shift (16, 8, 4, 2, then 1). It returns the result through a second valid/ready handshake. The single reused stage replaces the five-deep combinational mux chain, which shortens the critical path.

## Interface
- XLEN, 32: operand width; power of two, ≥ 4. Derived localparam SHW = log2(XLEN) sets the amount width and the number of stages.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  request ready; the request is accepted when i_valid & o_ready at a rising edge.
- i_op  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = reserved (executes as SRL).
- i_rs  input  XLEN  operand.
- i_amount  input  SHW  shift amount.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer ready; the result is taken when o_valid & i_ready at a rising edge.
- o_result  output  XLEN  shifted value.
- o_busy  output  1  high in SHIFT or DONE.

## Operation
- **Reset values:** state = IDLE, o_ready = 1, o_valid = 0, o_busy = 0, o_result = 0. Reset clears the internal operand, amount, op and stage registers to 0.
- **State machine:** IDLE, SHIFT, DONE.
- **IDLE:**
  - o_ready = 1.
  - On accept: latch i_rs into the working register, latch i_amount and i_op, latch fill = (op == SRA) ? i_rs[XLEN-1] : 0, set stage = SHW-1, go to SHIFT.
- **SHIFT:**
  - o_ready = 0.
  - Each cycle, if amount[stage] = 1, the working register is shifted by 2^stage:
    - SLL: zeros shift in at the LSB end.
    - SRL/SRA: the fill bit shifts in at the MSB end.
  - If amount[stage] = 0, the working register holds.
  - Decrement stage. After the stage-0 cycle, go to DONE.
- **DONE:**
  - o_valid = 1; o_result = working register, held stable while i_ready = 0.
  - o_ready = i_ready, which allows a back-to-back request.
  - On o_valid & i_ready:
    - With a simultaneous accept: load the new request and go to SHIFT; o_valid drops next cycle.
    - Without an accept: go to IDLE.
- **Inputs:** i_op, i_rs and i_amount are sampled only at accept; changes afterwards are ignored.
- **Invalid input:** none exists; the reserved op executes as SRL.
- **Reset mid-operation:** the in-flight request is discarded and no result is produced.

## Timing
- Accept at edge N: o_valid is high after edge N+SHW (5 cycles for XLEN = 32), independent of the amount. This latency applies unless SHIFT_EARLY_EXIT_EN is defined; see Configuration.
- Throughput: one result per SHW+1 cycles when back-to-back with i_ready held high; one per SHW+2 cycles when going through IDLE.
- Backpressure: DONE persists indefinitely. o_result must not change while o_valid = 1 and i_ready = 0.
- o_ready is a combinational function of state and i_ready. There is no other input-to-output combinational path.

## Configuration
- **SHIFT_EARLY_EXIT_EN defined:**
  - At accept with amount = 0: go directly to DONE with the result equal to the operand; o_valid is high after edge N+1.
  - In SHIFT: after processing stage s, if amount[s-1:0] == 0, go to DONE immediately.
  - Latency = SHW − p cycles, where p is the index of the lowest set bit of amount. For XLEN = 32: amount 16 → 1 cycle, amount 1 → 5 cycles.
- **Not defined:** latency is always SHW cycles, including for amount = 0.
- Results are identical in both builds; only latency differs.

## Test plan
- **Reset and basic SRL:** reset, then i_rs = 0x0000_00F0, SRL, amount 4 → o_result = 0x0000_000F. Without the macro, o_valid is high after exactly 5 edges; o_ready = 0 during SHIFT.
- **SRA sign fill:** i_rs = 0x8000_0000, SRA, amount 4 → 0xF800_0000. The same operand with SRL → 0x0800_0000.
- **SLL extreme and zero amount:** 0x0000_0001, SLL, amount 31 → 0x8000_0000. Amount 0 → 0x0000_0001 after 5 cycles; after 1 cycle with SHIFT_EARLY_EXIT_EN.
- **Backpressure and back-to-back:**
  - Hold i_ready = 0 for 10 cycles in DONE: o_result stays stable and o_ready = 0.
  - Then raise i_ready together with a new i_valid: the new request is accepted on the same edge, and its result follows SHW cycles later.
- **Reset mid-operation:** assert i_reset two cycles after accept → IDLE immediately, o_valid = 0, o_result = 0. A fresh request afterwards completes correctly.
- **Early-exit latency (macro defined):** amount 16 → 1 cycle, amount 8 → 2 cycles, amount 3 → 5 cycles. Results match the reference model in all cases.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Handshake bundle for shift_seq_ctrl: request channel (valid/ready plus operands)
// and result channel (valid/ready plus shifted value).
interface shift_seq_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned SHW = $clog2(XLEN);

  logic            i_valid;
  logic            o_ready;
  logic [1:0]      i_op;
  logic [XLEN-1:0] i_rs;
  logic [SHW-1:0]  i_amount;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport master (
    output i_valid, i_op, i_rs, i_amount, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_rs, i_amount, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer: one shared shift stage applies 2^stage per cycle.
// Optional SHIFT_EARLY_EXIT_EN leaves SHIFT once the remaining amount bits are all zero.
module shift_seq_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  shift_seq_ctrl_if.slave bus
);
  localparam int unsigned    SHW   = $clog2(XLEN);
  localparam logic [SHW-1:0] One   = SHW'(1);
  localparam logic [SHW-1:0] Top   = SHW'(SHW - 1);
  localparam logic [1:0]     OpSll = 2'b00;
  localparam logic [1:0]     OpSra = 2'b10;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  amt_q, amt_d;
  logic [SHW-1:0]  stage_q, stage_d;
  logic [1:0]      op_q, op_d;
  logic            fill_q, fill_d;

  logic            accept;
  logic            last_stage;
  logic [SHW-1:0]  step;
  logic [XLEN-1:0] shifted;

  assign step = One << stage_q;

  // Right shifts bring in the fill bit by shifting the complement with zero fill.
  always_comb begin
    if (op_q == OpSll) begin
      shifted = work_q << step;
    end else if (fill_q) begin
      shifted = ~((~work_q) >> step);
    end else begin
      shifted = work_q >> step;
    end
  end

`ifdef SHIFT_EARLY_EXIT_EN
  logic [SHW-1:0] low_mask;
  assign low_mask   = step - One;
  assign last_stage = ((amt_q & low_mask) == '0);
`else
  assign last_stage = (stage_q == '0);
`endif

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    amt_d        = amt_q;
    op_d         = op_q;
    fill_d       = fill_q;
    stage_d      = stage_q;
    accept       = 1'b0;
    bus.o_ready  = 1'b0;
    bus.o_valid  = 1'b0;
    bus.o_busy   = 1'b1;
    bus.o_result = '0;

    case (state_q)
      StIdle: begin
        bus.o_ready = 1'b1;
        bus.o_busy  = 1'b0;
        accept      = bus.i_valid;
      end
      StShift: begin
        if (amt_q[stage_q]) begin
          work_d = shifted;
        end
        stage_d = stage_q - One;
        if (last_stage) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bus.o_valid  = 1'b1;
        bus.o_result = work_q;
        bus.o_ready  = bus.i_ready;
        accept       = bus.i_valid & bus.i_ready;
        if (bus.i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A DONE-state hand-off overrides the return to IDLE.
    if (accept) begin
      work_d  = bus.i_rs;
      amt_d   = bus.i_amount;
      op_d    = bus.i_op;
      fill_d  = (bus.i_op == OpSra) & bus.i_rs[XLEN-1];
      stage_d = Top;
      state_d = StShift;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      fill_q  <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      stage_q <= stage_d;
    end
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed test-plan cases plus random traffic,
// checked every cycle against a transaction-level model (honours SHIFT_EARLY_EXIT_EN).
module tb_shift_seq_ctrl;
  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;
`ifdef SHIFT_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  shift_seq_ctrl_if #(.XLEN(XLEN)) bus ();

  shift_seq_ctrl #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] rs,
                                            input logic [4:0] amt);
    case (op)
      2'b00:   return rs << amt;
      2'b10:   return $signed(rs) >>> amt;
      default: return rs >> amt;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] amt);
    int early;
    early = 1;
    for (int p = SHW - 1; p >= 0; p--) begin
      if (amt[p]) early = SHW - p;
    end
    return EarlyExit ? early : SHW;
  endfunction

  // Transaction-level model: one job in flight, valid after ref_lat edges, held until taken.
  bit          m_busy, m_valid, m_first, m_acc, m_since_reset, m_lit_en;
  int          m_count, m_age, m_lit_lat;
  logic [31:0] m_res, m_lit;
  bit          s_lit_en;
  logic [31:0] s_lit;
  int          s_lit_lat;
  logic        acc_w, take_w;

  assign take_w = m_valid && bus.i_ready;
  assign acc_w  = bus.i_valid && (!m_busy || take_w);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_valid <= 0; m_first <= 0; m_acc <= 0; m_lit_en <= 0;
      m_count <= 0; m_age <= 0; m_res <= '0; m_since_reset <= 1;
    end else begin
      m_first <= 0;
      m_acc   <= acc_w;
      if (take_w) begin
        m_valid <= 0;
        m_busy  <= 0;
      end else if (m_busy && !m_valid) begin
        m_age   <= m_age + 1;
        m_count <= m_count - 1;
        if (m_count == 1) begin
          m_valid <= 1;
          m_first <= 1;
        end
      end
      if (acc_w) begin
        m_busy        <= 1;
        m_valid       <= 0;
        m_res         <= ref_shift(bus.i_op, bus.i_rs, bus.i_amount);
        m_count       <= ref_lat(bus.i_amount);
        m_age         <= 0;
        m_lit_en      <= s_lit_en;
        m_lit         <= s_lit;
        m_lit_lat     <= s_lit_lat;
        m_since_reset <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
    chk("o_busy", 32'(bus.o_busy), 32'(m_busy));
    chk("o_ready", 32'(bus.o_ready), 32'(!m_busy || (m_valid && bus.i_ready)));
    if (m_valid) chk("o_result", bus.o_result, m_res);
    if (m_since_reset) chk("o_result_after_reset", bus.o_result, 32'h0);
    if (m_first && m_lit_en) begin
      chk("literal_result", m_res, m_lit);
      chk("literal_latency", 32'(m_age), 32'(s_lit_lat_of_job()));
    end
  end

  function automatic int s_lit_lat_of_job();
    return m_lit_lat;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] op, input logic [31:0] rs, input logic [4:0] amt,
                         input logic [31:0] lit, input int lat_def, input int lat_ee,
                         input bit rdy);
    s_lit_en     = 1;
    s_lit        = lit;
    s_lit_lat    = EarlyExit ? lat_ee : lat_def;
    bus.i_valid  = 1;
    bus.i_op     = op;
    bus.i_rs     = rs;
    bus.i_amount = amt;
    bus.i_ready  = rdy;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_acc) break;
    end
    bus.i_valid  = 0;
    bus.i_rs     = $urandom;
    bus.i_amount = 5'($urandom);
    bus.i_op     = 2'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && m_busy; i++) tick();
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] rs, input logic [4:0] amt,
                     input logic [31:0] lit, input int lat_def, input int lat_ee);
    present(op, rs, amt, lit, lat_def, lat_ee, 1'b1);
    wait_accept();
    wait_idle();
  endtask

  initial begin
    bus.i_valid = 0; bus.i_op = 0; bus.i_rs = 0; bus.i_amount = 0; bus.i_ready = 0;
    s_lit_en = 0; s_lit = 0; s_lit_lat = 0;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    tick();

    run(2'b01, 32'h0000_00F0, 5'd4,  32'h0000_000F, 5, 3);
    run(2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 5, 3);
    run(2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 5, 3);
    run(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 5, 5);
    run(2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001, 5, 1);
    run(2'b01, 32'h1234_5678, 5'd16, 32'h0000_1234, 5, 1);
    run(2'b10, 32'hDEAD_BEEF, 5'd8,  32'hFFDE_ADBE, 5, 2);
    run(2'b00, 32'h0000_0011, 5'd3,  32'h0000_0088, 5, 5);
    run(2'b11, 32'h8000_0000, 5'd1,  32'h4000_0000, 5, 5);

    // Backpressure in DONE, then a same-edge hand-off to a new request.
    present(2'b10, 32'h8765_4321, 5'd12, 32'hFFF8_7654, 5, 3, 1'b0);
    wait_accept();
    for (int i = 0; i < 20 && !m_valid; i++) tick();
    repeat (10) tick();
    present(2'b00, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 5, 2, 1'b1);
    wait_accept();
    wait_idle();

    // Reset two cycles after accept, then a clean request.
    present(2'b01, 32'hFFFF_0000, 5'd1, 32'h7FFF_8000, 5, 5, 1'b1);
    wait_accept();
    tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    run(2'b01, 32'hFFFF_0000, 5'd1, 32'h7FFF_8000, 5, 5);

    s_lit_en = 0;
    for (int c = 0; c < 2000; c++) begin
      bus.i_valid = ($urandom_range(0, 1) == 1);
      bus.i_op    = 2'($urandom);
      bus.i_rs    = $urandom;
      case ($urandom_range(0, 5))
        0:       bus.i_amount = 5'd0;
        1:       bus.i_amount = 5'd31;
        2:       bus.i_amount = 5'd1 << $urandom_range(0, 4);
        default: bus.i_amount = 5'($urandom);
      endcase
      bus.i_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    bus.i_valid = 0;
    bus.i_ready = 1;
    repeat (20) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
